// File: rtl/clk_rst_seq_pkg.sv
// Shared types, default parameter values and sizing helper for the
// clock-enable / reset sequencer.
package clk_rst_seq_pkg;

   // Sequencer states: hold all resets, release channels in order, run.
   typedef enum logic [1:0] {
      ASSERT  = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2
   } seq_state_e;

   localparam int DEF_NUM_CH     = 4;
   localparam int DEF_DIV_W      = 8;
   localparam int DEF_DLY_W      = 8;
   localparam int DEF_MIN_ASSERT = 16;

   // Bits needed for a counter or index that spans 0..n-1 (never below 1).
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clk_en_div.sv
// One clock-enable divider channel. The counter sits at zero while the
// channel is in reset, so the first strobe after release is exactly 'div'
// cycles later; the strobe itself is combinational so a lowered divide
// value takes effect in the same cycle.
module clk_en_div
   import clk_rst_seq_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ch_rst,
   input  logic [DIV_W-1:0] div,
   output logic             clk_en
);

   logic [DIV_W-1:0] r_cnt;

   // Strobe whenever the count has reached (or overshot) the divide value.
   assign clk_en = !ch_rst && (r_cnt >= div);

   // Divider counter: cleared in reset, wraps on every strobe.
   always_ff @(posedge clk) begin
      if (rst || ch_rst) begin
         r_cnt <= '0;
      end else if (clk_en) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/clk_rst_seq.sv
// Reset sequencer: holds every channel in reset for MIN_ASSERT cycles after
// the global reset or a soft-reset request, then releases the channels one
// at a time in index order with per-channel gaps, and finally reports ready.
// Each channel also gets a divided clock-enable strobe.
module clk_rst_seq
   import clk_rst_seq_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int DIV_W      = DEF_DIV_W,
   parameter int DLY_W      = DEF_DLY_W,
   parameter int MIN_ASSERT = DEF_MIN_ASSERT
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CH-1:0][DIV_W-1:0]   div_i,
   input  logic [NUM_CH-1:0][DLY_W-1:0]   dly_i,
   input  logic                           soft_rst_req_i,
   output logic [NUM_CH-1:0]              ch_rst_o,
   output logic [NUM_CH-1:0]              ch_rst_n_o,
   output logic [NUM_CH-1:0]              clk_en_o,
   output logic                           ready_o
);

   localparam int                HOLD_W    = cnt_width(MIN_ASSERT);
   localparam int                IDX_W     = cnt_width(NUM_CH);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_ASSERT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);

   seq_state_e                  r_state,    w_state_next;
   logic [HOLD_W-1:0]           r_hold_cnt, w_hold_cnt_next;
   logic [DLY_W-1:0]            r_gap_cnt,  w_gap_cnt_next;
   logic [IDX_W-1:0]            r_idx,      w_idx_next;
   logic [NUM_CH-1:0][DLY_W-1:0] r_dly,     w_dly_next;
   logic [NUM_CH-1:0]           r_ch_rst,   w_ch_rst_next;
   logic [NUM_CH-1:0]           r_ch_rst_n;
   logic                        r_ready,    w_ready_next;

   // Sequencer state, shadow delays and registered reset/ready outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ASSERT;
         r_hold_cnt <= '0;
         r_gap_cnt  <= '0;
         r_idx      <= '0;
         r_dly      <= '0;
         r_ch_rst   <= '1;
         r_ch_rst_n <= '0;
         r_ready    <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_hold_cnt <= w_hold_cnt_next;
         r_gap_cnt  <= w_gap_cnt_next;
         r_idx      <= w_idx_next;
         r_dly      <= w_dly_next;
         r_ch_rst   <= w_ch_rst_next;
         r_ch_rst_n <= ~w_ch_rst_next;
         r_ready    <= w_ready_next;
      end
   end

   // Next-state logic: a soft request always restarts the hold phase from
   // zero; delays are frozen into shadow registers on RELEASE entry so that
   // live changes only matter for the next release sequence.
   always_comb begin
      w_state_next    = r_state;
      w_hold_cnt_next = r_hold_cnt;
      w_gap_cnt_next  = r_gap_cnt;
      w_idx_next      = r_idx;
      w_dly_next      = r_dly;
      w_ch_rst_next   = r_ch_rst;
      w_ready_next    = r_ready;

      if (soft_rst_req_i) begin
         w_state_next    = ASSERT;
         w_hold_cnt_next = '0;
         w_gap_cnt_next  = '0;
         w_idx_next      = '0;
         w_ch_rst_next   = '1;
         w_ready_next    = 1'b0;
      end else begin
         case (r_state)
            ASSERT: begin
               w_ch_rst_next = '1;
               w_ready_next  = 1'b0;
               if (r_hold_cnt == HOLD_LAST) begin
                  w_state_next   = RELEASE;
                  w_dly_next     = dly_i;
                  w_idx_next     = '0;
                  w_gap_cnt_next = '0;
               end else begin
                  w_hold_cnt_next = r_hold_cnt + 1'b1;
               end
            end
            RELEASE: begin
               if (r_gap_cnt == r_dly[r_idx]) begin
                  w_ch_rst_next[r_idx] = 1'b0;
                  w_gap_cnt_next       = '0;
                  if (r_idx == IDX_LAST) begin
                     w_state_next = RUN;
                     w_ready_next = 1'b1;
                  end else begin
                     w_idx_next = r_idx + 1'b1;
                  end
               end else begin
                  w_gap_cnt_next = r_gap_cnt + 1'b1;
               end
            end
            RUN: begin
               w_ready_next = 1'b1;
            end
            default: begin
               w_state_next    = ASSERT;
               w_hold_cnt_next = '0;
               w_ch_rst_next   = '1;
               w_ready_next    = 1'b0;
            end
         endcase
      end
   end

   // One divider per channel, each gated by that channel's registered reset.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_div
      clk_en_div #(
         .DIV_W (DIV_W)
      ) u_div (
         .clk    (clk),
         .rst    (rst),
         .ch_rst (r_ch_rst[gi]),
         .div    (div_i[gi]),
         .clk_en (clk_en_o[gi])
      );
   end

   assign ch_rst_o   = r_ch_rst;
   assign ch_rst_n_o = r_ch_rst_n;
   assign ready_o    = r_ready;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq: expected release edges and strobe patterns are
// queued when the stimulus is applied and popped as the outputs change.
module tb_clk_rst_seq;

   localparam int NUM_CH     = 4;
   localparam int DIV_W      = 8;
   localparam int DLY_W      = 8;
   localparam int MIN_ASSERT = 16;

   typedef struct {
      int ch;
      int at_edge;
   } rel_t;

   logic                         clk;
   logic                         rst;
   logic [NUM_CH-1:0][DIV_W-1:0] div_i;
   logic [NUM_CH-1:0][DLY_W-1:0] dly_i;
   logic                         soft_rst_req_i;
   logic [NUM_CH-1:0]            ch_rst_o;
   logic [NUM_CH-1:0]            ch_rst_n_o;
   logic [NUM_CH-1:0]            clk_en_o;
   logic                         ready_o;

   int   cyc;
   int   checks;
   int   errors;
   int   dly_m [NUM_CH];
   int   div_m [NUM_CH];
   int   rel_edge [NUM_CH];
   rel_t exp_q [$];
   logic [NUM_CH-1:0] en_q [$];
   logic bit_q [$];

   clk_rst_seq #(
      .NUM_CH     (NUM_CH),
      .DIV_W      (DIV_W),
      .DLY_W      (DLY_W),
      .MIN_ASSERT (MIN_ASSERT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .div_i          (div_i),
      .dly_i          (dly_i),
      .soft_rst_req_i (soft_rst_req_i),
      .ch_rst_o       (ch_rst_o),
      .ch_rst_n_o     (ch_rst_n_o),
      .clk_en_o       (clk_en_o),
      .ready_o        (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter: after posedge n has been seen, cyc == n.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic goto_edge(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Queue the expected release edges for a sequence whose last reset
   // (global or soft) was sampled at edge e_ref.
   task automatic push_seq(input int e_ref);
      int t;
      rel_t r;
      t = e_ref + MIN_ASSERT;
      for (int k = 0; k < NUM_CH; k++) begin
         t = t + dly_m[k] + 1;
         r.ch = k;
         r.at_edge = t;
         exp_q.push_back(r);
      end
   endtask

   // Watch channel resets fall and match each against the scoreboard.
   task automatic drain_releases(input int budget);
      logic [NUM_CH-1:0] prev;
      rel_t e;
      int n;
      prev = ch_rst_o;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(negedge clk);
         n++;
         checks++;
         if (ch_rst_n_o !== ~ch_rst_o) begin
            errors++;
            $display("FAIL rst_n_complement: edge %0d ch_rst_n_o=%b required %b", cyc, ch_rst_n_o, ~ch_rst_o);
         end
         for (int k = 0; k < NUM_CH; k++) begin
            if (prev[k] === 1'b1 && ch_rst_o[k] === 1'b0) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_release: ch %0d fell at edge %0d with nothing expected", k, cyc);
               end else begin
                  e = exp_q.pop_front();
                  rel_edge[k] = cyc;
                  if (e.ch != k || e.at_edge != cyc) begin
                     errors++;
                     $display("FAIL release_order: ch %0d fell at edge %0d, required ch %0d at edge %0d", k, cyc, e.ch, e.at_edge);
                  end else begin
                     $display("release ch %0d at edge %0d", k, cyc);
                  end
               end
               checks++;
               if (ready_o !== 1'(k == NUM_CH - 1)) begin
                  errors++;
                  $display("FAIL ready_on_release: ch %0d edge %0d ready_o=%b required %b", k, cyc, ready_o, (k == NUM_CH - 1));
               end
            end
         end
         prev = ch_rst_o;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL release_timeout: %0d releases still pending at edge %0d", exp_q.size(), cyc);
         exp_q.delete();
      end
   endtask

   task automatic pulse_soft(input int s);
      goto_edge(s - 1);
      soft_rst_req_i = 1'b1;
      goto_edge(s);
      soft_rst_req_i = 1'b0;
   endtask

   task automatic test_reset();
      goto_edge(9);
      @(negedge clk);
      checks++;
      if (ch_rst_o !== '1 || ch_rst_n_o !== '0 || clk_en_o !== '0 || ready_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: ch_rst=%b rst_n=%b en=%b ready=%b required 1111 0000 0000 0", ch_rst_o, ch_rst_n_o, clk_en_o, ready_o);
      end else begin
         $display("reset values ok at edge %0d", cyc);
      end
      goto_edge(10);
      rst = 1'b0;
   endtask

   task automatic test_default_sequence();
      push_seq(10);
      drain_releases(60);
   endtask

   // Compare every strobe for ~530 cycles against the period model.
   task automatic test_dividers();
      logic [NUM_CH-1:0] exp_v;
      logic [NUM_CH-1:0] got_v;
      int c0;
      int d;
      c0 = cyc + 1;
      for (int c = c0; c < c0 + 530; c++) begin
         for (int k = 0; k < NUM_CH; k++) begin
            d = c - rel_edge[k];
            exp_v[k] = (d >= 0) && ((d % (div_m[k] + 1)) == div_m[k]);
         end
         en_q.push_back(exp_v);
      end
      while (en_q.size() > 0) begin
         @(negedge clk);
         exp_v = en_q.pop_front();
         got_v = clk_en_o;
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL divider_strobe: edge %0d clk_en_o=%b required %b", cyc, got_v, exp_v);
         end
      end
      $display("divider window ends at edge %0d", cyc);
   endtask

   task automatic test_soft_run();
      int s;
      s = cyc + 3;
      pulse_soft(s);
      push_seq(s);
      @(negedge clk);
      checks++;
      if (ch_rst_o !== '1 || ch_rst_n_o !== '0 || clk_en_o !== '0 || ready_o !== 1'b0) begin
         errors++;
         $display("FAIL soft_run_assert: ch_rst=%b rst_n=%b en=%b ready=%b required 1111 0000 0000 0", ch_rst_o, ch_rst_n_o, clk_en_o, ready_o);
      end else begin
         $display("soft reset in RUN at edge %0d", s);
      end
      drain_releases(60);
   endtask

   task automatic test_soft_mid_release();
      int s1;
      int s2;
      rel_t r;
      s1 = cyc + 3;
      pulse_soft(s1);
      r.ch = 0; r.at_edge = s1 + MIN_ASSERT + 1;
      exp_q.push_back(r);
      r.ch = 1; r.at_edge = s1 + MIN_ASSERT + 5;
      exp_q.push_back(r);
      drain_releases(40);
      s2 = s1 + MIN_ASSERT + 6;
      pulse_soft(s2);
      push_seq(s2);
      @(negedge clk);
      checks++;
      if (ch_rst_o !== '1 || ready_o !== 1'b0) begin
         errors++;
         $display("FAIL soft_mid_release: ch_rst=%b ready=%b required 1111 0", ch_rst_o, ready_o);
      end else begin
         $display("soft reset mid-release at edge %0d", s2);
      end
      drain_releases(60);
   endtask

   task automatic test_dly_change();
      int s;
      s = cyc + 3;
      pulse_soft(s);
      push_seq(s);
      goto_edge(s + MIN_ASSERT);
      dly_i[3] = 8'd0;
      drain_releases(60);
      dly_i[3] = 8'd5;
   endtask

   task automatic test_global_rst_run();
      int r;
      r = cyc + 3;
      goto_edge(r - 1);
      rst = 1'b1;
      goto_edge(r);
      rst = 1'b0;
      push_seq(r);
      @(negedge clk);
      checks++;
      if (ch_rst_o !== '1 || ch_rst_n_o !== '0 || clk_en_o !== '0 || ready_o !== 1'b0) begin
         errors++;
         $display("FAIL global_rst_run: ch_rst=%b rst_n=%b en=%b ready=%b required 1111 0000 0000 0", ch_rst_o, ch_rst_n_o, clk_en_o, ready_o);
      end else begin
         $display("global reset in RUN at edge %0d", r);
      end
      drain_releases(60);
   endtask

   task automatic test_div_shrink();
      int n;
      logic exp_b;
      n = 0;
      while (clk_en_o[3] !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (clk_en_o[3] !== 1'b1) begin
         errors++;
         $display("FAIL shrink_wait_strobe: no ch3 strobe within 300 cycles, clk_en_o=%b", clk_en_o);
      end else begin
         div_i[3] = 8'd200;
         @(posedge clk);
         for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (clk_en_o[3] !== 1'b0) begin
               errors++;
               $display("FAIL shrink_pre_count: count %0d clk_en_o[3]=%b required 0", i, clk_en_o[3]);
            end
         end
         div_i[3] = 8'd2;
         bit_q.push_back(1'b1);
         for (int p = 0; p < 2; p++) begin
            bit_q.push_back(1'b0);
            bit_q.push_back(1'b0);
            bit_q.push_back(1'b1);
         end
         while (bit_q.size() > 0) begin
            @(negedge clk);
            exp_b = bit_q.pop_front();
            checks++;
            if (clk_en_o[3] !== exp_b) begin
               errors++;
               $display("FAIL shrink_strobe: edge %0d clk_en_o[3]=%b required %b", cyc, clk_en_o[3], exp_b);
            end
         end
         $display("div shrink 200->2 checked at edge %0d", cyc);
      end
   endtask

   initial begin
      cyc = 0;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      soft_rst_req_i = 1'b0;
      dly_m[0] = 0; dly_m[1] = 3; dly_m[2] = 1; dly_m[3] = 5;
      div_m[0] = 0; div_m[1] = 1; div_m[2] = 3; div_m[3] = 255;
      for (int k = 0; k < NUM_CH; k++) begin
         dly_i[k] = DLY_W'(dly_m[k]);
         div_i[k] = DIV_W'(div_m[k]);
         rel_edge[k] = 0;
      end

      test_reset();
      test_default_sequence();
      test_dividers();
      test_soft_run();
      test_soft_mid_release();
      test_dly_change();
      test_global_rst_run();
      test_div_shrink();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
